// File: rtl/dequant_pkg.sv
// rtl/dequant_pkg.sv - shared widths, FSM state type and arithmetic helpers for dequantize_stream
package dequant_pkg;

    localparam int LANES  = 4;
    localparam int Q_W    = 8;
    localparam int ACC_W  = 32;
    localparam int PROD_W = 64;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Half-LSB bias added before the arithmetic shift: rounds half toward +inf.
    function automatic logic signed [PROD_W-1:0] round_bias(input int shift);
        logic signed [PROD_W-1:0] bias;
        bias = '0;
        if (shift > 0) begin
            bias = {{(PROD_W-1){1'b0}}, 1'b1} << (shift - 1);
        end
        return bias;
    endfunction

    function automatic logic [ACC_W-1:0] sat_acc(input logic signed [PROD_W-1:0] v);
        logic signed [PROD_W-1:0] acc_max;
        logic signed [PROD_W-1:0] acc_min;
        logic [ACC_W-1:0]         res;
        acc_max = {{(PROD_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
        acc_min = {{(PROD_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
        if (v > acc_max) begin
            res = {1'b0, {(ACC_W-1){1'b1}}};
        end else if (v < acc_min) begin
            res = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            res = v[ACC_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/dequant_lane.sv
// rtl/dequant_lane.sv - combinational int8 lane dequantizer (subtract, multiply, round, shift); DEQUANT_SAT_EN clamps to int32
module dequant_lane
    import dequant_pkg::*;
#(
    parameter logic signed [ACC_W-1:0] MULT_VAL   = 1,
    parameter int                      SHIFT_VAL  = 0,
    parameter int                      ZERO_POINT = 0
) (
    input  logic [Q_W-1:0]   i_q,
    output logic [ACC_W-1:0] o_r
);

    localparam logic signed [Q_W:0]      ZP   = (Q_W+1)'(ZERO_POINT);
    localparam logic signed [PROD_W-1:0] MULT = PROD_W'(MULT_VAL);
    localparam logic signed [PROD_W-1:0] BIAS = round_bias(SHIFT_VAL);

    logic signed [Q_W:0]      w_d;
    logic signed [PROD_W-1:0] w_d_ext;
    logic signed [PROD_W-1:0] w_p;
    logic signed [PROD_W-1:0] w_r;

    // 9 bits cover q - zp over the full int8 x int8 range without overflow.
    assign w_d     = $signed({i_q[Q_W-1], i_q}) - ZP;
    assign w_d_ext = PROD_W'(w_d);
    assign w_p     = w_d_ext * MULT;
    assign w_r     = (w_p + BIAS) >>> SHIFT_VAL;

`ifdef DEQUANT_SAT_EN
    assign o_r = sat_acc(w_r);
`else
    assign o_r = ACC_W'(w_r);
`endif

endmodule

// File: rtl/dequantize_stream.sv
// rtl/dequantize_stream.sv - streaming int8x4 to int32 dequantizer; DEQUANT_SAT_EN enables output saturation
module dequantize_stream
    import dequant_pkg::*;
#(
    parameter logic signed [ACC_W-1:0] MULT_VAL   = 1,
    parameter int                      SHIFT_VAL  = 0,
    parameter int                      ZERO_POINT = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [LANES*Q_W-1:0] i_in_data,
    input  logic                 i_in_last,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [ACC_W-1:0]     o_out_data,
    output logic                 o_out_last
);

    state_t               r_state;
    logic [LANES*Q_W-1:0] r_word;
    logic                 r_last;
    logic [LANE_W-1:0]    r_lane;
    logic [ACC_W-1:0]     r_out_data;
    logic                 r_out_valid;
    logic                 r_out_last;

    logic                 w_load;
    logic                 w_take;
    logic                 w_lane_end;
    logic                 w_accept;
    logic [Q_W-1:0]       w_q;
    logic [ACC_W-1:0]     w_r;

    // Output stage may load when empty or drained this cycle; a lane moves only then.
    assign w_load     = !r_out_valid || i_out_ready;
    assign w_take     = (r_state == EMIT) && w_load;
    assign w_lane_end = (r_lane == LANE_W'(LANES - 1));
    assign o_in_ready = (r_state == IDLE) || (w_lane_end && w_take);
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_q        = r_word[r_lane*Q_W +: Q_W];

    dequant_lane #(
        .MULT_VAL  (MULT_VAL),
        .SHIFT_VAL (SHIFT_VAL),
        .ZERO_POINT(ZERO_POINT)
    ) u_lane (
        .i_q(w_q),
        .o_r(w_r)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_word      <= '0;
            r_last      <= 1'b0;
            r_lane      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_valid <= (r_state == EMIT);
                r_out_last  <= (r_state == EMIT) && w_lane_end && r_last;
                if (r_state == EMIT) begin
                    r_out_data <= w_r;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_word  <= i_in_data;
                        r_last  <= i_in_last;
                        r_lane  <= '0;
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    if (w_take) begin
                        if (w_lane_end) begin
                            // Last lane leaves; refill in the same cycle to avoid a bubble.
                            r_lane <= '0;
                            if (w_accept) begin
                                r_word <= i_in_data;
                                r_last <= i_in_last;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_lane <= r_lane + LANE_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_out_last  = r_out_last;

endmodule

// File: tb/tb_dequantize_stream.sv
// tb/tb_dequantize_stream.sv - self-checking bench for dequantize_stream over four parameter sets
module tb_dequantize_stream;

    localparam int NDUT = 4;
    localparam int P_MULT [NDUT] = '{1, 3, 32'h7FFFFFFF, -98765};
    localparam int P_SH   [NDUT] = '{0, 1, 0, 5};
    localparam int P_ZP   [NDUT] = '{0, 5, 0, -7};
    localparam longint LMAX = 64'sd2147483647;
    localparam longint LMIN = -64'sd2147483648;

`ifdef DEQUANT_SAT_EN
    localparam logic [127:0] EXP_BIG = {32'h80000000, 32'h80000001, 32'h00000000, 32'h7FFFFFFF};
`else
    localparam logic [127:0] EXP_BIG = {32'h00000002, 32'h80000001, 32'h00000000, 32'hFFFFFFFE};
`endif

    typedef struct packed {
        logic [1:0]        dut;
        logic [31:0]       data;
        logic              last;
        logic [3:0][31:0]  exp;
        logic              exp_last;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [NDUT-1:0]  in_valid;
    logic [NDUT-1:0]  in_last;
    logic [NDUT-1:0]  out_ready;
    logic [31:0]      in_data [NDUT];
    wire  [NDUT-1:0]  in_ready;
    wire  [NDUT-1:0]  out_valid;
    wire  [NDUT-1:0]  out_last;
    wire  [31:0]      out_data [NDUT];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dequantize_stream #(
            .MULT_VAL  (P_MULT[g]),
            .SHIFT_VAL (P_SH[g]),
            .ZERO_POINT(P_ZP[g])
        ) u_dut (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_in_valid (in_valid[g]),
            .o_in_ready (in_ready[g]),
            .i_in_data  (in_data[g]),
            .i_in_last  (in_last[g]),
            .o_out_valid(out_valid[g]),
            .i_out_ready(out_ready[g]),
            .o_out_data (out_data[g]),
            .o_out_last (out_last[g])
        );
    end

    // Reference: exact rational value floor((q - zp) * mult / 2^sh + 1/2).
    function automatic logic [31:0] model(input int d, input logic [7:0] q);
        longint p, dv, num, r;
        p = (longint'($signed(q)) - longint'(P_ZP[d])) * longint'(P_MULT[d]);
        if (P_SH[d] == 0) begin
            r = p;
        end else begin
            dv  = longint'(1) << P_SH[d];
            num = p + dv / 2;
            r   = num / dv;
            if ((num % dv) != 0 && num < 0) r = r - 1;
        end
`ifdef DEQUANT_SAT_EN
        if (r > LMAX) r = LMAX;
        else if (r < LMIN) r = LMIN;
`endif
        return r[31:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic offer(input int d, input logic [31:0] data, input logic last);
        int n;
        @(negedge clk);
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        in_last[d]  = last;
        #1;
        n = 0;
        while (!in_ready[d] && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept", in_ready[d], 1);
    endtask

    task automatic run_vec(input vec_t v);
        int d;
        d = int'(v.dut);
        offer(d, v.data, v.last);
        @(negedge clk);
        in_valid[d] = 1'b0;
        #1;
        chk("latency_gap", out_valid[d], 0);
        for (int l = 0; l < 4; l++) begin
            @(negedge clk);
            #1;
            chk("vec_valid", out_valid[d], 1);
            chk("vec_data", out_data[d], v.exp[l]);
            chk("vec_last", out_last[d], (l == 3) ? v.exp_last : 1'b0);
        end
        @(negedge clk);
        #1;
        chk("vec_tail", out_valid[d], 0);
    endtask

    task automatic rand_run(input int d, input int ncyc);
        logic [32:0] exq [$];
        logic [32:0] exp_e;
        logic [32:0] held_v;
        logic [31:0] w;
        logic        acc;
        logic        held;
        acc  = 1'b0;
        held = 1'b0;
        held_v = '0;
        in_valid[d] = 1'b0;
        for (int c = 0; c < ncyc + 40; c++) begin
            @(negedge clk);
            if (!in_valid[d] || acc) begin
                if (c < ncyc && $urandom_range(3) != 0) begin
                    in_valid[d] = 1'b1;
                    in_data[d]  = $urandom;
                    in_last[d]  = 1'($urandom_range(1));
                end else begin
                    in_valid[d] = 1'b0;
                end
            end
            acc = 1'b0;
            out_ready[d] = (c >= ncyc) || ($urandom_range(3) != 0);
            #1;
            if (held) chk("rand_hold", {out_last[d], out_data[d]}, held_v);
            held   = out_valid[d] && !out_ready[d];
            held_v = {out_last[d], out_data[d]};
            if (in_valid[d] && in_ready[d]) begin
                acc = 1'b1;
                w   = in_data[d];
                for (int l = 0; l < 4; l++) begin
                    exq.push_back({in_last[d] && (l == 3), model(d, w[l*8 +: 8])});
                end
            end
            if (out_valid[d] && out_ready[d]) begin
                if (exq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rand_extra: got %0h want nothing", out_data[d]);
                end else begin
                    exp_e = exq.pop_front();
                    chk("rand_out", {out_last[d], out_data[d]}, exp_e);
                end
            end
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        chk("rand_drain", exq.size(), 0);
    endtask

    vec_t         vecs [6];
    logic [31:0]  b2b_w [3];
    logic [31:0]  bw;
    vec_t         rv;
    int           nacc;
    int           k;

    initial begin
        vecs[0] = '{dut: 2'd0, data: 32'h80FF017F, last: 1'b1,
                    exp: {32'hFFFFFF80, 32'hFFFFFFFF, 32'h00000001, 32'h0000007F}, exp_last: 1'b1};
        vecs[1] = '{dut: 2'd0, data: 32'h00000000, last: 1'b0, exp: '0, exp_last: 1'b0};
        vecs[2] = '{dut: 2'd1, data: 32'h80050406, last: 1'b1,
                    exp: {32'hFFFFFF39, 32'h00000000, 32'hFFFFFFFF, 32'h00000002}, exp_last: 1'b1};
        vecs[3] = '{dut: 2'd2, data: 32'hFEFF0002, last: 1'b0, exp: EXP_BIG, exp_last: 1'b0};
        vecs[4] = '{dut: 2'd3, data: 32'hF900807F, last: 1'b1,
                    exp: {32'h00000000, 32'hFFFFAB9B, 32'h0005B2CF, 32'hFFF9B076}, exp_last: 1'b1};
        vecs[5] = '{dut: 2'd2, data: 32'h01010101, last: 1'b1,
                    exp: {4{32'h7FFFFFFF}}, exp_last: 1'b1};
        b2b_w[0] = 32'h01FF7F80;
        b2b_w[1] = 32'h12345678;
        b2b_w[2] = 32'h9ABCDEF0;

        rst       = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        out_ready = '1;
        for (int d = 0; d < NDUT; d++) in_data[d] = '0;
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk("rst_valid", out_valid[d], 0);
            chk("rst_data", out_data[d], 0);
            chk("rst_last", out_last[d], 0);
            chk("rst_ready", in_ready[d], 1);
        end
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Backpressure: stall three cycles while lane 1 is presented.
        offer(1, 32'h80050406, 1'b1);
        @(negedge clk);
        in_valid[1] = 1'b0;
        @(negedge clk);
        #1;
        chk("bp_lane0", out_data[1], 32'h00000002);
        @(negedge clk);
        out_ready[1] = 1'b0;
        #1;
        chk("bp_lane1", out_data[1], 32'hFFFFFFFF);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            #1;
            chk("bp_valid", out_valid[1], 1);
            chk("bp_stable", out_data[1], 32'hFFFFFFFF);
            chk("bp_in_ready", in_ready[1], 0);
        end
        out_ready[1] = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_lane2", {out_valid[1], out_last[1], out_data[1]}, {2'b10, 32'h00000000});
        @(negedge clk);
        #1;
        chk("bp_lane3", {out_valid[1], out_last[1], out_data[1]}, {2'b11, 32'hFFFFFF39});
        @(negedge clk);
        #1;
        chk("bp_tail", out_valid[1], 0);

        // Back-to-back words on a permanently ready sink.
        nacc = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (nacc < 3) begin
                in_valid[0] = 1'b1;
                in_data[0]  = b2b_w[nacc];
                in_last[0]  = (nacc == 2);
            end else begin
                in_valid[0] = 1'b0;
            end
            #1;
            chk("b2b_in_ready", in_ready[0], ((c % 4) == 0 || c >= 12) ? 1 : 0);
            if (in_valid[0] && in_ready[0]) nacc++;
            chk("b2b_valid", out_valid[0], (c >= 2 && c <= 13) ? 1 : 0);
            if (c >= 2 && c <= 13) begin
                k  = c - 2;
                bw = b2b_w[k / 4];
                chk("b2b_data", out_data[0], model(0, bw[(k % 4)*8 +: 8]));
                chk("b2b_last", out_last[0], (k == 11) ? 1 : 0);
            end
        end
        chk("b2b_words", nacc, 3);

        // Reset after lane 1 has been emitted.
        offer(0, 32'h11223344, 1'b0);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_lane0", out_data[0], 32'h00000044);
        @(negedge clk);
        #1;
        chk("mid_lane1", out_data[0], 32'h00000033);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_valid", out_valid[0], 0);
        chk("mid_rst_ready", in_ready[0], 1);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            #1;
            chk("mid_quiet", out_valid[0], 0);
        end
        rv = '{dut: 2'd0, data: 32'h55667788, last: 1'b1,
               exp: {32'h00000055, 32'h00000066, 32'h00000077, 32'hFFFFFF88}, exp_last: 1'b1};
        run_vec(rv);

        rand_run(3, 500);
        rand_run(1, 300);
        rand_run(2, 300);
        rand_run(0, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dequantize_stream.md
# dequantize_stream

Streaming int8-to-int32 dequantizer for the inference datapath; it is the inverse of the requantization stage. It accepts 32-bit words of four packed int8 activations or weights, subtracts a zero point, then applies a fixed multiplier and a rounding right shift. It emits one int32 value per cycle in the accumulator domain. It sits between the int8 feature-map buffers and the fixed-point consumers (bias add, softmax/debug readback), with valid/ready flow control on both sides.

## Interface
- `MULT_VAL`, 1: signed 32-bit multiplier.
- `SHIFT_VAL`, 0: right-shift amount, 0..31.
- `ZERO_POINT`, 0: signed int8 zero point, -128..127.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: input word valid.
- `in_ready`  out  1: block can accept a word.
- `in_data`  in  32: four signed int8 lanes; lane 0 = [7:0] is emitted first, lane 3 = [31:24] last.
- `in_last`  in  1: word is the final word of a tensor.
- `out_valid`  out  1: output value valid.
- `out_ready`  in  1: consumer accepts the value.
- `out_data`  out  32: signed dequantized value.
- `out_last`  out  1: high only on lane 3 of a word accepted with `in_last`.

## Operation
- Per lane: `d = q - ZERO_POINT`, a 9-bit signed value.
- `p = d * MULT_VAL`, computed at 64-bit signed width.
- If `SHIFT_VAL > 0`: `r = (p + (1 << (SHIFT_VAL-1))) >>> SHIFT_VAL`, which rounds half toward +inf.
- If `SHIFT_VAL == 0`: `r = p`.
- Output is `r`, reduced to 32 bits per the Configuration section.
- Stage A is a word register with a 2-bit lane counter and an FSM:
  - `IDLE`: buffer empty.
  - `EMIT`: buffer holds a word; the lane counter selects the current lane.
- Stage B is the output register holding `out_data`, `out_valid`, `out_last`.
- Stage B loads when it is empty or `out_ready` is high. The lane counter advances only on that load.
- `EMIT` to `IDLE`: lane 3 moves into stage B and no new word is accepted in the same cycle.
- `EMIT` to `EMIT` with a new word: lane 3 moves into stage B while `in_valid && in_ready`. The lane counter resets to 0 and the new word and `in_last` are loaded.
- `in_ready = (state == IDLE) || (lane == 3 && stageB_load)`. `in_ready` is combinational from state and `out_ready`, with no combinational path from `in_valid`.
- Stage B holds `out_data` and `out_last` stable while `out_valid && !out_ready`.
- Reset values:
  - `out_valid = 0`, `out_data = 0`, `out_last = 0`, `in_ready = 1` (state `IDLE`), lane counter = 0.
- Reset mid-word: all buffered lanes are discarded and no partial output is emitted after reset.

## Timing
- A word accepted at edge N has lane 0 `out_valid` high after edge N+1, so latency is 2 edges.
- Sustained throughput is 1 lane per cycle, i.e. 1 word per 4 cycles, with no bubble between back-to-back words when `out_ready` stays high.
- A backpressure stall of k cycles delays all subsequent outputs by exactly k cycles. No lane is lost or duplicated.
- `in_ready` is low for cycles 1–3 of each word's emission.

## Configuration
- `DEQUANT_SAT_EN` defined: `r` is clamped to [-2^31, 2^31-1] before output.
- `DEQUANT_SAT_EN` undefined: `out_data = r[31:0]` (two's-complement wrap). This saves comparator area.

## Structure
- Package `dequant_pkg` holds:
  - `LANES = 4`, `Q_W = 8`, `ACC_W = 32`, `PROD_W = 64`.
  - The FSM state typedef with states `IDLE` and `EMIT`.
- Sub-module `dequant_lane`: combinational arithmetic for one int8 lane, covering subtract, multiply, round, shift and the optional saturation. It is instantiated once on the lane-mux output.

## Test plan
- Basic order and values:
  - Setup: ZP=0, MULT=1, SHIFT=0; `in_data = 0x80FF017F`, `in_last = 1`.
  - Required: outputs 127, 1, -1, -128 on 4 consecutive cycles, `out_last` high only on -128, first output 2 edges after acceptance.
- Zero point and rounding:
  - Setup: ZP=5, MULT=3, SHIFT=1; lanes q = 6, 4, 5, -128.
  - Required: outputs 2, -1, 0, -199 (since (-133·3+1)>>>1 = -199).
- Saturation:
  - Setup: ZP=0, MULT=0x7FFFFFFF, SHIFT=0; lane q=2.
  - Required: output 0x7FFFFFFF with `DEQUANT_SAT_EN`, 0xFFFFFFFE without it.
- Backpressure:
  - Stimulus: hold `out_ready` low for 3 cycles while lane 1 is valid.
  - Required: `out_data` is stable, `in_ready` stays 0, and the full sequence resumes intact with no duplicates.
- Back-to-back:
  - Stimulus: 3 words with `in_valid` held high and `out_ready` = 1.
  - Required: 12 outputs on 12 consecutive cycles and `in_ready` pulses every 4th cycle.
- Reset mid-word:
  - Stimulus: assert `rst` after lane 1 is emitted.
  - Required: next cycle `out_valid = 0` and `in_ready = 1`. A subsequent word emits from lane 0 with no stale lanes.
